prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that fills the instruction memory before the CPU core runs. It frames an incoming byte stream as a word count followed by big-endian 32-bit instructions and writes each completed word to consecutive instruction-memory addresses from 0. It holds the CPU in reset for the whole load and releases it when the load completes successfully. It is the write side of the instruction memory, which the CPU otherwise only reads.

## Interface
- ADDR_W, 5: instruction-memory address width; DEPTH = 2**ADDR_W words.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Accepted only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_waddr  out  ADDR_W  write address.
- imem_wdata  out  32  write data.
- cpu_hold  out  1  drives the CPU core's rst; high holds the core in reset.
- done  out  1  load completed successfully; level signal.
- error  out  1  load aborted; level signal.

## Operation
- States: IDLE, HDR, DATA, CHK (only with CHECKSUM_EN), DONE, ERR.
- IDLE:
  - start -> HDR.
  - in_ready=0.
- HDR:
  - Accepts one byte N.
  - If N in 1..DEPTH: latch remaining=N, clear waddr, clear byte_idx and checksum, go to DATA.
  - Otherwise (N=0 or N>DEPTH): go to ERR.
- DATA:
  - Bytes are accepted MSB first.
  - byte_idx counts 0..3 and wraps to 0 after the 4th byte of each word.
  - The 4th byte completes the word and triggers the write.
  - After the write, waddr increments and remaining decrements.
  - Once the last word is written: go to CHK if CHECKSUM_EN is defined, otherwise DONE.
- DONE / ERR: start re-enters HDR, giving a reload or retry.
- in_ready = 1 in HDR, DATA and CHK; 0 in all other states.
- cpu_hold = 0 only in DONE.
- start is ignored in HDR, DATA and CHK.
- Reset mid-load:
  - All state returns to reset values.
  - Words already written stay in memory; they are not cleared.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, done=0, error=0.

## Timing
- All outputs are registered.
- Word write: 4th byte accepted at edge k -> imem_we=1 with wdata/waddr valid in cycle k+1, for exactly one cycle.
- Waddr increment: imem_waddr increments at the end of cycle k+1.
- DONE entry (no checksum): done=1 and cpu_hold=0 from cycle k+2 after the final word's 4th byte.
- DONE entry (checksum): done=1 and cpu_hold=0 one cycle after the checksum byte is accepted.
- Header errors: error=1 one cycle after the bad header byte.
- in_ready stays high during a write cycle. The next write cannot occur sooner than 4 cycles later.
- start pulse: done and error clear in the cycle after start; state=HDR.

## Configuration
- CHECKSUM_EN defined:
  - Running XOR of all data bytes (header excluded).
  - After the last word, CHK accepts one byte.
  - Match -> DONE.
  - Mismatch -> ERR, with cpu_hold=1 and error=1. Words already written remain in memory.
- CHECKSUM_EN undefined:
  - No CHK state and no checksum register.
  - The load goes straight to DONE.

## Structure
- Package loader_pkg holds:
  - the state enum;
  - BYTES_PER_WORD=4;
  - the HDR error rule (valid count range).
- Sub-module word_assembler:
  - Shifts bytes MSB first into a 32-bit register.
  - Keeps the 2-bit byte counter.
  - Pulses word_valid on the 4th byte.
- The top level holds the FSM, waddr and remaining counters, and the checksum.

## Test plan
- Nominal load: start, header 0x02, bytes 01 23 45 67 89 AB CD EF -> writes 0x01234567@0 then 0x89ABCDEF@1, each imem_we one cycle; then done=1 and cpu_hold=0.
- Bad header 0x00: start, header 0x00 -> error=1 one cycle later, cpu_hold=1, no imem_we.
- Bad header 0x21: start, header 0x21 (>32) -> error=1 one cycle later, cpu_hold=1, no imem_we.
- Full depth and backpressure: header 0x20 with 128 bytes and in_valid toggled randomly -> 32 writes, waddr 0..31, no byte lost; done=1.
- Checksum (CHECKSUM_EN): one word DE AD BE EF with checksum 0x22 -> done=1. Same word with checksum 0x23 -> error=1, while 0xDEADBEEF@0 is still written.
- Reset and reload: rst asserted after 2 of 4 bytes -> all reset values. Then a fresh start with header 0x01 and word 0x00000013 -> write @0 and done=1. A further start in DONE -> done=0 and cpu_hold=1 the next cycle.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and rules for the program loader: FSM states, word framing and the header count rule.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
`ifdef CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  // A header is usable only if it names between one word and a full memory.
  function automatic logic hdr_count_ok(input logic [7:0] n, input int depth);
    return (int'(n) >= 1) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port out; the loader sits on the slave side.
interface prog_loader_if #(parameter int ADDR_W = 5);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs bytes MSB first into a 32-bit word and pulses word_valid the cycle after the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      word       <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (byte_en) begin
        word     <= {word[23:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'(BYTES_PER_WORD - 1))
          word_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: frames a byte stream into instruction-memory writes and holds the CPU in reset meanwhile.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE_LEFT = (ADDR_W + 1)'(1);

  state_t            state, next_state;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] waddr;
  logic              in_ready_q;
  logic              ready_next;
  logic              take;
  logic              final_write;
  logic              byte_en;
  logic [31:0]       word;
  logic              word_valid;
`ifdef CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  assign take        = bus.in_valid && in_ready_q;
  assign final_write = word_valid && (remaining == ONE_LEFT);
  // A byte arriving alongside the last write belongs to the checksum, never to a new word.
  assign byte_en     = take && (state == DATA) && !final_write;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == HDR),
    .byte_en    (byte_en),
    .byte_in    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = HDR;
      HDR:  if (take) next_state = hdr_count_ok(bus.in_data, DEPTH) ? DATA : ERR;
      DATA: begin
`ifdef CHECKSUM_EN
        if (final_write) begin
          if (take) next_state = (bus.in_data == checksum) ? DONE : ERR;
          else      next_state = CHK;
        end
`else
        if (final_write) next_state = DONE;
`endif
      end
`ifdef CHECKSUM_EN
      CHK:  if (take) next_state = (bus.in_data == checksum) ? DONE : ERR;
`endif
      DONE: if (start) next_state = HDR;
      ERR:  if (start) next_state = HDR;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_next = (next_state == HDR) || (next_state == DATA);
`ifdef CHECKSUM_EN
    if (next_state == CHK) ready_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Status outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      in_ready_q <= ready_next;
      cpu_hold   <= (next_state != DONE);
      done       <= (next_state == DONE);
      error      <= (next_state == ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr     <= '0;
      remaining <= '0;
    end else if ((state == HDR) && take) begin
      waddr     <= '0;
      remaining <= (ADDR_W + 1)'(bus.in_data);
    end else if (word_valid) begin
      waddr     <= waddr + 1'b1;
      remaining <= remaining - ONE_LEFT;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                checksum <= '0;
    else if (state == HDR)  checksum <= '0;
    else if (byte_en)       checksum <= checksum ^ bus.in_data;
  end
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = word_valid;
  assign bus.imem_waddr = waddr;
  assign bus.imem_wdata = word;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader; expected writes come from a word-list model of the load.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, done, error;
  int   tests = 0;
  int   fails = 0;
  wr_t  sb[$];

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(5)) bus ();

  prog_loader #(.ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.imem_we) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: addr %0d data 0x%08h, none expected", bus.imem_waddr, bus.imem_wdata);
        end else begin
          wr_t exp_wr;
          exp_wr = sb.pop_front();
          check_output("write_addr", 32'(bus.imem_waddr), 32'(exp_wr.addr));
          check_output("write_data", bus.imem_wdata, exp_wr.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int   budget;
    logic ready_seen;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
    end
    budget = 0;
    forever begin
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      ready_seen   = bus.in_ready;
      @(posedge clk);
      if (ready_seen) break;
      budget++;
      if (budget > 200) begin
        tests++;
        fails++;
        $display("[TB] FAIL byte_accept_timeout: in_ready stuck at 0, expected 1");
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("start_done_clear", 32'(done), 32'd0);
    check_output("start_error_clear", 32'(error), 32'd0);
    check_output("start_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("start_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // One complete load: model the expected writes and outcome, then drive the stream.
  task automatic apply_stimulus(input logic [7:0] hdr, input byte_q_t data, input bit gaps, input bit bad_chk);
    logic [7:0] xsum;
    bit         ok;
    xsum = 8'h00;
    ok   = (hdr >= 8'd1) && (hdr <= 8'd32);
    if (ok) begin
      for (int i = 0; i < int'(hdr); i++)
        sb.push_back('{addr: 5'(i), data: {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]}});
    end
    foreach (data[i]) xsum ^= data[i];
    pulse_start();
    send_byte(hdr, gaps);
    if (!ok) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_output("hdr_error", 32'(error), 32'd1);
      check_output("hdr_cpu_hold", 32'(cpu_hold), 32'd1);
      check_output("hdr_done", 32'(done), 32'd0);
      return;
    end
    foreach (data[i]) send_byte(data[i], gaps);
`ifdef CHECKSUM_EN
    send_byte(bad_chk ? (xsum ^ 8'h01) : xsum, gaps);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_output("chk_done", 32'(done), 32'(!bad_chk));
    check_output("chk_error", 32'(error), 32'(bad_chk));
    check_output("chk_cpu_hold", 32'(cpu_hold), 32'(bad_chk));
`else
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_output("done_not_early", 32'(done), 32'd0);
    @(negedge clk);
    check_output("load_done", 32'(done), 32'd1);
    check_output("load_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("load_error", 32'(error), 32'd0);
    if (bad_chk) check_output("checksum_unused", 32'(error), 32'd0);
`endif
    check_output("writes_outstanding", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_output({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check_output({tag, "_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check_output({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #1000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    byte_q_t q;
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    apply_stimulus(8'h02, '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}, 1'b0, 1'b0);
    apply_stimulus(8'h00, '{}, 1'b0, 1'b0);
    apply_stimulus(8'h21, '{}, 1'b0, 1'b0);

    q = '{};
    for (int i = 0; i < 128; i++) q.push_back(8'($urandom));
    apply_stimulus(8'h20, q, 1'b1, 1'b0);

    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, 8);
      q = '{};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      apply_stimulus(8'(n), q, 1'($urandom), 1'b0);
    end

`ifdef CHECKSUM_EN
    apply_stimulus(8'h01, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0, 1'b0);
    apply_stimulus(8'h01, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0, 1'b1);
`endif

    // Reset partway through a word, then a clean reload and a restart from DONE.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midload_reset");
    apply_stimulus(8'h01, '{8'h00, 8'h00, 8'h00, 8'h13}, 1'b0, 1'b0);
    pulse_start();

    repeat (3) @(negedge clk);
    check_output("final_outstanding", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
